// File: rtl/bcd_pkg.sv
// Shared constants for the BCD converters (binary-to-BCD encoder and
// BCD-to-binary decoder): FSM state encoding, default sizes and the
// double-dabble digit adjust threshold/value.
package bcd_pkg;

    // Handshake FSM states shared by both converter directions.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } bcd_state_e;

    // Default sizing: three decimal digits fit in ten bits (999 < 1024).
    localparam int DEF_DIGITS = 3;
    localparam int DEF_BIN_W  = 10;

    // Reverse double-dabble: after a right shift, any digit >= 8 loses 3.
    localparam logic [3:0] ADJ_THRESHOLD = 4'd8;
    localparam logic [3:0] ADJ_VALUE     = 4'd3;

    // Largest legal decimal digit.
    localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit correction step of reverse double-dabble.
// Ports:
//   field    - 4-bit BCD digit field taken from the freshly shifted register
//   adjusted - field - 3 when field >= 8, otherwise field unchanged
// The subtraction cannot underflow because it only happens for field >= 8.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] field,
    output logic [3:0] adjusted
);

    // Conditional subtract-3 correction of one digit.
    always_comb begin
        adjusted = field;
        if (field >= ADJ_THRESHOLD) begin
            adjusted = field - ADJ_VALUE;
        end else begin
            adjusted = field;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to unsigned-binary converter (reverse double-dabble,
// one shift/adjust iteration per clock) with a start/done/ack handshake.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-low reset
//   start  - conversion request, sampled only in IDLE
//   bcd    - packed BCD input, digit 0 in bits [3:0], captured on start
//   ack    - consumer acknowledge, honoured only in DONE
//   binary - converted result, valid while done=1, kept after ack
//   done   - result available, held until ack
//   busy   - high while converting or holding a result
//   error  - raised together with done when an input digit exceeds 9
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W  = DEF_BIN_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  ack,
    output logic [BIN_W-1:0]      binary,
    output logic                  done,
    output logic                  busy,
    output logic                  error
);

    localparam int SH_W  = 4*DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    // True when any packed digit is outside 0..9.
    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > DIGIT_MAX) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    bcd_state_e          state_r, state_n_s;
    logic [SH_W-1:0]     shift_r, shift_n_s;
    logic [CNT_W-1:0]    cnt_r, cnt_n_s;
    logic [BIN_W-1:0]    binary_r, binary_n_s;
    logic                done_r, done_n_s;
    logic                busy_r, busy_n_s;
    logic                error_r, error_n_s;

    logic [SH_W-1:0]     shifted_s;
    logic [4*DIGITS-1:0] adj_digits_s;
    logic [SH_W-1:0]     iter_s;

    // One iteration: shift right, then correct every BCD digit field.
    assign shifted_s = shift_r >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .field    (shifted_s[BIN_W + 4*g +: 4]),
            .adjusted (adj_digits_s[4*g +: 4])
        );
    end

    assign iter_s = {adj_digits_s, shifted_s[BIN_W-1:0]};

    // Next-state and next-output logic of the handshake FSM.
    always_comb begin
        state_n_s  = state_r;
        shift_n_s  = shift_r;
        cnt_n_s    = cnt_r;
        binary_n_s = binary_r;
        done_n_s   = done_r;
        error_n_s  = error_r;
        busy_n_s   = busy_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (has_bad_digit(bcd)) begin
                        // Illegal input skips conversion and reports at once.
                        binary_n_s = {BIN_W{1'b0}};
                        done_n_s   = 1'b1;
                        error_n_s  = 1'b1;
                        state_n_s  = ST_DONE;
                    end else begin
                        shift_n_s  = {bcd, {BIN_W{1'b0}}};
                        cnt_n_s    = {CNT_W{1'b0}};
                        done_n_s   = 1'b0;
                        error_n_s  = 1'b0;
                        state_n_s  = ST_CONVERT;
                    end
                end else begin
                    done_n_s  = 1'b0;
                    error_n_s = 1'b0;
                    state_n_s = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                shift_n_s = iter_s;
                cnt_n_s   = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_ITER) begin
                    // Final iteration: the low bits now hold the binary value.
                    binary_n_s = iter_s[BIN_W-1:0];
                    done_n_s   = 1'b1;
                    error_n_s  = 1'b0;
                    state_n_s  = ST_DONE;
                end else begin
                    state_n_s  = ST_CONVERT;
                end
            end
            ST_DONE: begin
                if (ack) begin
                    done_n_s  = 1'b0;
                    error_n_s = 1'b0;
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_DONE;
                end
            end
            default: begin
                done_n_s  = 1'b0;
                error_n_s = 1'b0;
                state_n_s = ST_IDLE;
            end
        endcase

        busy_n_s = (state_n_s == ST_CONVERT) || (state_n_s == ST_DONE);
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            shift_r  <= {SH_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            binary_r <= {BIN_W{1'b0}};
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_n_s;
            shift_r  <= shift_n_s;
            cnt_r    <= cnt_n_s;
            binary_r <= binary_n_s;
            done_r   <= done_n_s;
            busy_r   <= busy_n_s;
            error_r  <= error_n_s;
        end
    end

    assign binary = binary_r;
    assign done   = done_r;
    assign busy   = busy_r;
    assign error  = error_r;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed testbench for bcd_to_binary (DIGITS=3, BIN_W=10).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_bcd_to_binary;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] bcd;
    logic        ack;
    logic [9:0]  binary;
    logic        done;
    logic        busy;
    logic        error;

    int n_checks;
    int n_fail;

    bcd_to_binary #(.DIGITS(3), .BIN_W(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bcd    (bcd),
        .ack    (ack),
        .binary (binary),
        .done   (done),
        .busy   (busy),
        .error  (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle with value v, then count falling edges
    // until done (n=1 is the first falling edge after the start edge).
    task automatic pulse_and_wait(input logic [11:0] v, output int n);
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One-cycle acknowledge.
    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        bcd   = 12'h000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({binary, done, busy, error} !== {10'h000, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL reset_state: got binary=%h done=%b busy=%b error=%b, want 000/0/0/0",
                     binary, done, busy, error);
            n_fail++;
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        @(negedge clk);
        bcd   = 12'h999;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL basic_busy: got busy=%b done=%b, want 1/0", busy, done);
            n_fail++;
        end
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== 11) begin
            $display("FAIL basic_latency: got %0d cycles, want 11", n);
            n_fail++;
        end
        n_checks++;
        if (binary !== 10'h3E7 || error !== 1'b0) begin
            $display("FAIL basic_999: got binary=%h error=%b, want 3e7/0", binary, error);
            n_fail++;
        end
        do_ack();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || binary !== 10'h3E7) begin
            $display("FAIL basic_ack: got done=%b busy=%b binary=%h, want 0/0/3e7", done, busy, binary);
            n_fail++;
        end
    endtask

    task automatic test_zero_255();
        int n;
        pulse_and_wait(12'h000, n);
        n_checks++;
        if (n !== 11 || binary !== 10'h000 || error !== 1'b0) begin
            $display("FAIL zero: got n=%0d binary=%h error=%b, want 11/000/0", n, binary, error);
            n_fail++;
        end
        do_ack();
        pulse_and_wait(12'h255, n);
        n_checks++;
        if (n !== 11 || binary !== 10'h0FF || error !== 1'b0) begin
            $display("FAIL val_255: got n=%0d binary=%h error=%b, want 11/0ff/0", n, binary, error);
            n_fail++;
        end
        do_ack();
    endtask

    task automatic test_invalid();
        int n;
        pulse_and_wait(12'h1A3, n);
        n_checks++;
        if (n !== 1 || error !== 1'b1 || binary !== 10'h000 || busy !== 1'b1) begin
            $display("FAIL invalid: got n=%0d error=%b binary=%h busy=%b, want 1/1/000/1",
                     n, error, binary, busy);
            n_fail++;
        end
        do_ack();
        n_checks++;
        if (done !== 1'b0 || error !== 1'b0) begin
            $display("FAIL invalid_ack: got done=%b error=%b, want 0/0", done, error);
            n_fail++;
        end
    endtask

    task automatic test_handshake_hold();
        int n;
        int bad;
        @(negedge clk);
        bcd   = 12'h512;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Stray start during CONVERT.
        bcd   = 12'h007;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 3;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== 11 || binary !== 10'h200) begin
            $display("FAIL hold_convert: got n=%0d binary=%h, want 11/200", n, binary);
            n_fail++;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            // Stray start during DONE partway through the hold.
            start = (i == 10) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (done !== 1'b1 || binary !== 10'h200 || busy !== 1'b1) bad++;
        end
        start = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            $display("FAIL hold_done: %0d of 20 cycles lost done/binary=200 (last binary=%h done=%b)",
                     bad, binary, done);
            n_fail++;
        end
        do_ack();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL hold_ack: got done=%b busy=%b, want 0/0", done, busy);
            n_fail++;
        end
        pulse_and_wait(12'h007, n);
        n_checks++;
        if (n !== 11 || binary !== 10'd7) begin
            $display("FAIL hold_restart: got n=%0d binary=%h, want 11/007", n, binary);
            n_fail++;
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        bcd   = 12'h888;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (binary !== 10'h000 || done !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            $display("FAIL reset_mid: got binary=%h done=%b busy=%b error=%b, want 000/0/0/0",
                     binary, done, busy, error);
            n_fail++;
        end
        reset = 1'b1;
        pulse_and_wait(12'h888, n);
        n_checks++;
        if (n !== 11 || binary !== 10'h378) begin
            $display("FAIL reset_mid_restart: got n=%0d binary=%h, want 11/378", n, binary);
            n_fail++;
        end
        do_ack();
    endtask

    task automatic test_round_trip();
        int n;
        logic [11:0] v;
        logic [9:0]  want;
        for (int i = 0; i < 1000; i++) begin
            v = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            want = 10'(i);
            pulse_and_wait(v, n);
            n_checks++;
            if (n !== 11 || binary !== want || error !== 1'b0) begin
                $display("FAIL round_trip %0d: got n=%0d binary=%h error=%b, want 11/%h/0",
                         i, n, binary, error, want);
                n_fail++;
            end
            do_ack();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_zero_255();
        test_invalid();
        test_handshake_hold();
        test_reset_mid();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
